// File: rtl/brom_pkg.sv
// Shared definitions for the boot ROM access arbiter.
//   state_t     - FSM encoding (IDLE / READ / HOLD)
//   PORT_FETCH  - requester index of instruction fetch (port 0)
//   PORT_DATA   - requester index of the data load bus (port 1)
//   ROM_WORDS_DEFAULT, ADDR_WIDTH_DEFAULT - default ROM depth and address width
package brom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int ROM_WORDS_DEFAULT  = 166;
  localparam int ADDR_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/brom_access_arbiter_if.sv
// Bundle of the two requester ports and the ROM port of the boot ROM arbiter.
//   slave  - arbiter side: takes requests/addresses/ROM data, drives ready/rdata/error/ROM enable+address
//   master - environment side (bus bridge and ROM): the mirror image
interface brom_access_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  i_p0_request;
  logic [ADDR_WIDTH-1:0] i_p0_address;
  logic [31:0]           o_p0_rdata;
  logic                  o_p0_ready;
  logic                  i_p1_request;
  logic [ADDR_WIDTH-1:0] i_p1_address;
  logic [31:0]           o_p1_rdata;
  logic                  o_p1_ready;
  logic                  o_p1_error;
  logic                  o_rom_enable;
  logic [ADDR_WIDTH-1:0] o_rom_address;
  logic [31:0]           i_rom_rdata;

  modport slave (
    input  i_p0_request, i_p0_address, i_p1_request, i_p1_address, i_rom_rdata,
    output o_p0_rdata, o_p0_ready, o_p1_rdata, o_p1_ready, o_p1_error,
           o_rom_enable, o_rom_address
  );

  modport master (
    output i_p0_request, i_p0_address, i_p1_request, i_p1_address, i_rom_rdata,
    input  o_p0_rdata, o_p0_ready, o_p1_rdata, o_p1_ready, o_p1_error,
           o_rom_enable, o_rom_address
  );

endinterface

// File: rtl/brom_rr_grant.sv
// Combinational two-way round-robin grant.
//   request[1:0] - pending requests of port 1 / port 0
//   last_grant   - port that won the previous arbitration
//   grant        - winning port (meaningful only when valid=1)
//   valid        - at least one port is requesting
// On a tie the port that did not win last time is chosen.
module brom_rr_grant (
  input  logic [1:0] request,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |request;
    grant = 1'b0;
    if (&request) grant = ~last_grant;
    else          grant = request[1];
  end

endmodule

// File: rtl/brom_access_arbiter.sv
// Shares the single-port boot ROM between instruction fetch (port 0) and the
// data load bus (port 1), sequencing the ROM's edge-triggered enable and
// returning the word over a four-phase request/ready handshake.
//   i_clock - system clock, rising edge
//   i_reset - asynchronous active-high reset
//   bus     - requester ports and ROM port (brom_access_arbiter_if.slave)
//
// state | meaning
// IDLE  | waiting for a request; grants and launches the ROM access
// READ  | ROM enable pulse done, capture ROM data and raise ready
// HOLD  | ready held until the winner drops its request
module brom_access_arbiter
  import brom_pkg::*;
#(
  parameter int ROM_WORDS  = ROM_WORDS_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  brom_access_arbiter_if.slave  bus
);

  localparam logic [ADDR_WIDTH-3:0] ROM_LIMIT = (ADDR_WIDTH-2)'(ROM_WORDS);

  state_t                state;
  logic                  last_grant;
  logic                  winner;
  logic                  grant;
  logic                  grant_valid;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [ADDR_WIDTH-1:0] word_address;
  logic                  in_range;
  logic                  winner_request;

  brom_rr_grant u_rr_grant (
    .request    ({bus.i_p1_request, bus.i_p0_request}),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_valid)
  );

  assign sel_address    = (grant == PORT_DATA) ? bus.i_p1_address : bus.i_p0_address;
  assign word_address   = sel_address & ~ADDR_WIDTH'(3);
  assign in_range       = word_address[ADDR_WIDTH-1:2] < ROM_LIMIT;
  assign winner_request = (winner == PORT_DATA) ? bus.i_p1_request : bus.i_p0_request;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state             <= IDLE;
      last_grant        <= PORT_DATA;
      winner            <= PORT_FETCH;
      bus.o_p0_rdata    <= '0;
      bus.o_p0_ready    <= 1'b0;
      bus.o_p1_rdata    <= '0;
      bus.o_p1_ready    <= 1'b0;
      bus.o_p1_error    <= 1'b0;
      bus.o_rom_enable  <= 1'b0;
      bus.o_rom_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            winner            <= grant;
            last_grant        <= grant;
            bus.o_rom_address <= word_address;
            if (in_range) begin
              bus.o_rom_enable <= 1'b1;
              state            <= READ;
            end else begin
              // Out-of-range: answer immediately with zero data, no ROM cycle.
              if (grant == PORT_DATA) begin
                bus.o_p1_rdata <= '0;
                bus.o_p1_ready <= 1'b1;
                bus.o_p1_error <= 1'b1;
              end else begin
                bus.o_p0_rdata <= '0;
                bus.o_p0_ready <= 1'b1;
              end
              state <= HOLD;
            end
          end
        end
        READ: begin
          bus.o_rom_enable <= 1'b0;
          if (winner == PORT_DATA) begin
            bus.o_p1_rdata <= bus.i_rom_rdata;
            bus.o_p1_ready <= 1'b1;
          end else begin
            bus.o_p0_rdata <= bus.i_rom_rdata;
            bus.o_p0_ready <= 1'b1;
          end
          state <= HOLD;
        end
        HOLD: begin
          bus.o_p1_error <= 1'b0;
          if (!winner_request) begin
            if (winner == PORT_DATA) bus.o_p1_ready <= 1'b0;
            else                     bus.o_p0_ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
